// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//
// A countdown timer that holds the remaining time in BCD as minutes, seconds
// and 10 ms units. An internal prescaler turns clk_core into a 10 ms tick, and
// each tick takes one 10 ms unit off the count. The outputs drive the
// 7-segment display mux directly.
//
// Optional feature macro: BCD_COUNTDOWN_AUTO_RELOAD_EN
//   When defined, a shadow register keeps the last accepted non-zero preset.
//   On expiry from RUN the count is reloaded from the shadow and counting
//   continues.
//   When undefined, the timer stops in EXPIRED and no shadow register exists.
//
// Parameters:
//   CLK_DIV     clk_core cycles per 10 ms tick (>= 2)
//   MIN_DIGITS  number of BCD minute digits (1..4)
//
// Ports:
//   clk_core    system clock; all logic runs on its rising edge
//   rst         asynchronous active-high reset
//   load        1-cycle pulse: capture the preset from min_i/sec_i/ms_10_i
//   start       1-cycle pulse: begin or resume counting (ARMED -> RUN)
//   pause       1-cycle pulse: freeze counting (RUN -> ARMED)
//   min_i       preset minutes, BCD, digit 0 in the LSBs
//   sec_i       preset seconds, BCD 00..59
//   ms_10_i     preset 10 ms units, BCD 00..99
//   min_o       remaining minutes, BCD
//   sec_o       remaining seconds, BCD
//   ms_10_o     remaining 10 ms units, BCD
//   running     high while the timer is in RUN
//   time_out    sticky expiry flag
//   done_pulse  one-cycle pulse on expiry
//   bad_preset  one-cycle pulse when a load is rejected
//
// All outputs come straight from registers, so no path runs combinationally
// from an input to an output.

module bcd_countdown_timer #(
  parameter int unsigned CLK_DIV    = 100000,
  parameter int unsigned MIN_DIGITS = 2
) (
  input  logic                    clk_core,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    start,
  input  logic                    pause,
  input  logic [4*MIN_DIGITS-1:0] min_i,
  input  logic [7:0]              sec_i,
  input  logic [7:0]              ms_10_i,
  output logic [4*MIN_DIGITS-1:0] min_o,
  output logic [7:0]              sec_o,
  output logic [7:0]              ms_10_o,
  output logic                    running,
  output logic                    time_out,
  output logic                    done_pulse,
  output logic                    bad_preset
);

  localparam int unsigned PresW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned NDigits = MIN_DIGITS + 4;
  localparam int unsigned CntW    = 4 * NDigits;
  localparam logic [PresW-1:0] PresMax = PresW'(CLK_DIV - 1);

  // The count is packed as {minutes, seconds, ms_10}. Digit 0 is the 10 ms
  // units digit and digit 3 is the seconds tens digit.
  localparam int unsigned SecTensIdx = 3;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun,
    StExpired
  } state_e;

  state_e           state_q, state_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             running_q, running_d;
  logic             time_out_q, time_out_d;
  logic             done_q, done_d;
  logic             bad_q, bad_d;

  logic [CntW-1:0]  preset;
  logic             preset_ok;
  logic             tick;
  logic             last_unit;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  logic [CntW-1:0]  shadow_q, shadow_d;
`endif

  // Largest legal value of each digit position. The seconds tens digit
  // stops at 5; every other digit goes up to 9.
  function automatic logic [3:0] digit_max(input int unsigned k);
    return (k == SecTensIdx) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic preset_valid(input logic [CntW-1:0] p);
    logic ok;
    ok = 1'b1;
    for (int unsigned k = 0; k < NDigits; k++) begin
      if (p[4*k +: 4] > digit_max(k)) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Subtract one 10 ms unit. A digit at zero wraps to its maximum and passes
  // the borrow on. Once a digit absorbs the borrow, the digits above it are
  // left untouched.
  function automatic logic [CntW-1:0] bcd_dec(input logic [CntW-1:0] c);
    logic [CntW-1:0] r;
    logic            borrow;
    logic [3:0]      d;
    r      = c;
    borrow = 1'b1;
    for (int unsigned k = 0; k < NDigits; k++) begin
      d = c[4*k +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*k +: 4] = digit_max(k);
        end else begin
          r[4*k +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign preset    = {min_i, sec_i, ms_10_i};
  assign preset_ok = preset_valid(preset);
  assign tick      = (state_q == StRun) && (presc_q == PresMax);
  // A count of 0..0:00:01 is exactly the value 1 in this packing.
  assign last_unit = (cnt_q == CntW'(1));

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    time_out_d = time_out_q;
    done_d     = 1'b0;
    bad_d      = 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    shadow_d   = shadow_q;
`endif

    // Priority: load > pause > start > counting. A cycle that carries a load
    // or a pause never decrements, even when it is a tick cycle.
    if (load) begin
      if (!preset_ok) begin
        bad_d = 1'b1;
      end else begin
        cnt_d      = preset;
        presc_d    = '0;
        time_out_d = 1'b0;
        if (preset == '0) begin
          state_d    = StExpired;
          time_out_d = 1'b1;
          done_d     = 1'b1;
        end else begin
          state_d = StArmed;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
          shadow_d = preset;
`endif
        end
      end
    end else if (pause) begin
      // The prescaler is held, so a resume finishes the partial tick.
      if (state_q == StRun) begin
        state_d = StArmed;
      end
    end else if (start && (state_q == StArmed)) begin
      state_d = StRun;
    end else if (state_q == StRun) begin
      if (tick) begin
        presc_d = '0;
        if (last_unit) begin
          done_d = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
          cnt_d = shadow_q;
`else
          cnt_d      = '0;
          state_d    = StExpired;
          time_out_d = 1'b1;
`endif
        end else if (cnt_q != '0) begin
          cnt_d = bcd_dec(cnt_q);
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      cnt_q      <= '0;
      running_q  <= 1'b0;
      time_out_q <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      running_q  <= running_d;
      time_out_q <= time_out_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
    end
  end

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  assign min_o      = cnt_q[CntW-1 -: 4*MIN_DIGITS];
  assign sec_o      = cnt_q[15:8];
  assign ms_10_o    = cnt_q[7:0];
  assign running    = running_q;
  assign time_out   = time_out_q;
  assign done_pulse = done_q;
  assign bad_preset = bad_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer with CLK_DIV=4 and MIN_DIGITS=2.
// A vector table covers the main sequences. Hand-written sequences cover
// expiry, auto-reload (when the macro is defined) and asynchronous reset.
// Expected outputs go into a scoreboard queue when each stimulus is driven.
// They are popped and compared one cycle later, after the sampling edge.

module tb_bcd_countdown_timer;

  localparam int unsigned ClkDiv    = 4;
  localparam int unsigned MinDigits = 2;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif

  logic       clk_core = 1'b0;
  logic       rst      = 1'b0;
  logic       load     = 1'b0;
  logic       start    = 1'b0;
  logic       pause    = 1'b0;
  logic [7:0] min_i    = '0;
  logic [7:0] sec_i    = '0;
  logic [7:0] ms_10_i  = '0;
  logic [7:0] min_o;
  logic [7:0] sec_o;
  logic [7:0] ms_10_o;
  logic       running;
  logic       time_out;
  logic       done_pulse;
  logic       bad_preset;

  bcd_countdown_timer #(
    .CLK_DIV    (ClkDiv),
    .MIN_DIGITS (MinDigits)
  ) dut (
    .clk_core   (clk_core),
    .rst        (rst),
    .load       (load),
    .start      (start),
    .pause      (pause),
    .min_i      (min_i),
    .sec_i      (sec_i),
    .ms_10_i    (ms_10_i),
    .min_o      (min_o),
    .sec_o      (sec_o),
    .ms_10_o    (ms_10_o),
    .running    (running),
    .time_out   (time_out),
    .done_pulse (done_pulse),
    .bad_preset (bad_preset)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic        ld;
    logic        st;
    logic        ps;
    logic [7:0]  mn;
    logic [7:0]  sc;
    logic [7:0]  ms;
    logic [27:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [27:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Expected output word: {min, sec, ms_10, running, time_out, done, bad}.
  function automatic logic [27:0] e(input logic [7:0] mn, input logic [7:0] sc,
                                    input logic [7:0] ms, input logic run,
                                    input logic to, input logic dn, input logic bad);
    return {mn, sc, ms, run, to, dn, bad};
  endfunction

  function automatic void add(input logic ld, input logic st, input logic ps,
                              input logic [7:0] mn, input logic [7:0] sc,
                              input logic [7:0] ms, input logic [27:0] ex,
                              input string nm);
    vec_t v;
    v.ld = ld; v.st = st; v.ps = ps;
    v.mn = mn; v.sc = sc; v.ms = ms;
    v.exp = ex; v.name = nm;
    vecs.push_back(v);
  endfunction

  function automatic void add_idle(input int n, input logic [27:0] ex, input string nm);
    for (int i = 0; i < n; i++) begin
      add(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, ex, nm);
    end
  endfunction

  task automatic check_pop();
    logic [27:0] ex;
    logic [27:0] act;
    string       nm;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expected value queued");
      return;
    end
    ex  = exp_q.pop_front();
    nm  = name_q.pop_front();
    act = {min_o, sec_o, ms_10_o, running, time_out, done_pulse, bad_preset};
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s @%0t: got min=%h sec=%h ms=%h run=%b to=%b done=%b bad=%b, expected min=%h sec=%h ms=%h run=%b to=%b done=%b bad=%b",
               nm, $time, act[27:20], act[19:12], act[11:4], act[3], act[2], act[1], act[0],
               ex[27:20], ex[19:12], ex[11:4], ex[3], ex[2], ex[1], ex[0]);
    end
  endtask

  task automatic check_now(input logic [27:0] ex, input string nm);
    exp_q.push_back(ex);
    name_q.push_back(nm);
    check_pop();
  endtask

  // Inputs change 1 time unit after a rising edge. Outputs are sampled
  // 1 time unit after the next rising edge.
  task automatic step(input logic ld, input logic st, input logic ps,
                      input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] ms,
                      input logic [27:0] ex, input string nm);
    load = ld; start = st; pause = ps;
    min_i = mn; sec_i = sc; ms_10_i = ms;
    exp_q.push_back(ex);
    name_q.push_back(nm);
    @(posedge clk_core);
    #1;
    check_pop();
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic idle(input logic [27:0] ex, input string nm);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, ex, nm);
  endtask

  initial begin
    // Basic countdown 00:00:03 to expiry.
    add_idle(1, e(8'h00, 8'h00, 8'h00, 0, 0, 0, 0), "idle_after_reset");
    add(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h00, 0, 0, 0, 0), "start_in_idle");
    add(1, 0, 0, 8'h00, 8'h00, 8'h03, e(8'h00, 8'h00, 8'h03, 0, 0, 0, 0), "load_3");
    add(0, 0, 1, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h03, 0, 0, 0, 0), "pause_in_armed");
    add(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h03, 1, 0, 0, 0), "start_3");
    add_idle(3, e(8'h00, 8'h00, 8'h03, 1, 0, 0, 0), "run_3");
    add_idle(1, e(8'h00, 8'h00, 8'h02, 1, 0, 0, 0), "tick_to_2");
    add_idle(3, e(8'h00, 8'h00, 8'h02, 1, 0, 0, 0), "run_2");
    add_idle(1, e(8'h00, 8'h00, 8'h01, 1, 0, 0, 0), "tick_to_1");
    add_idle(3, e(8'h00, 8'h00, 8'h01, 1, 0, 0, 0), "run_1");
    add_idle(1, e(8'h00, 8'h00, Auto ? 8'h03 : 8'h00, Auto, !Auto, 1, 0), "expire");
    add_idle(1, e(8'h00, 8'h00, Auto ? 8'h03 : 8'h00, Auto, !Auto, 0, 0), "after_expire");
    add(0, 1, 0, 8'h00, 8'h00, 8'h00,
        e(8'h00, 8'h00, Auto ? 8'h03 : 8'h00, Auto, !Auto, 0, 0), "start_in_expired");
    add(1, 0, 0, 8'h00, 8'h60, 8'h00,
        e(8'h00, 8'h00, Auto ? 8'h03 : 8'h00, Auto, !Auto, 0, 1), "bad_sec_60");
    // Borrow chains.
    add(1, 0, 0, 8'h01, 8'h00, 8'h00, e(8'h01, 8'h00, 8'h00, 0, 0, 0, 0), "load_1min");
    add(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h01, 8'h00, 8'h00, 1, 0, 0, 0), "start_1min");
    add_idle(3, e(8'h01, 8'h00, 8'h00, 1, 0, 0, 0), "run_1min");
    add_idle(1, e(8'h00, 8'h59, 8'h99, 1, 0, 0, 0), "borrow_00_59_99");
    add(1, 0, 0, 8'h10, 8'h00, 8'h00, e(8'h10, 8'h00, 8'h00, 0, 0, 0, 0), "load_10min_in_run");
    add(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h10, 8'h00, 8'h00, 1, 0, 0, 0), "start_10min");
    add_idle(3, e(8'h10, 8'h00, 8'h00, 1, 0, 0, 0), "run_10min");
    add_idle(1, e(8'h09, 8'h59, 8'h99, 1, 0, 0, 0), "borrow_09_59_99");
    // Rejected loads in RUN leave the count, the state and the prescaler alone.
    add(1, 0, 0, 8'h00, 8'h00, 8'h1A, e(8'h09, 8'h59, 8'h99, 1, 0, 0, 1), "bad_ms_1a");
    add(1, 0, 0, 8'hA0, 8'h00, 8'h00, e(8'h09, 8'h59, 8'h99, 1, 0, 0, 1), "bad_min_a0");
    add_idle(3, e(8'h09, 8'h59, 8'h99, 1, 0, 0, 0), "run_after_bad");
    add_idle(1, e(8'h09, 8'h59, 8'h98, 1, 0, 0, 0), "tick_to_98");
    add(1, 0, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h00, 0, 1, 1, 0), "load_zero");
    add_idle(1, e(8'h00, 8'h00, 8'h00, 0, 1, 0, 0), "after_load_zero");
    // Pause and resume keep the partial tick.
    add(1, 0, 0, 8'h00, 8'h00, 8'h05, e(8'h00, 8'h00, 8'h05, 0, 0, 0, 0), "load_5");
    add(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h05, 1, 0, 0, 0), "start_5");
    add_idle(2, e(8'h00, 8'h00, 8'h05, 1, 0, 0, 0), "run_5");
    add(0, 0, 1, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h05, 0, 0, 0, 0), "pause_5");
    add_idle(20, e(8'h00, 8'h00, 8'h05, 0, 0, 0, 0), "paused_hold");
    add(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h05, 1, 0, 0, 0), "resume_5");
    add_idle(1, e(8'h00, 8'h00, 8'h05, 1, 0, 0, 0), "resume_partial");
    add_idle(1, e(8'h00, 8'h00, 8'h04, 1, 0, 0, 0), "resume_tick_to_4");
    // A load and a pause that land on tick cycles both win over the decrement.
    add_idle(3, e(8'h00, 8'h00, 8'h04, 1, 0, 0, 0), "run_4");
    add(1, 0, 0, 8'h00, 8'h00, 8'h07, e(8'h00, 8'h00, 8'h07, 0, 0, 0, 0), "load_on_tick");
    add(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h07, 1, 0, 0, 0), "start_7");
    add_idle(3, e(8'h00, 8'h00, 8'h07, 1, 0, 0, 0), "run_7");
    add(0, 0, 1, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h07, 0, 0, 0, 0), "pause_on_tick");
    add(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h07, 1, 0, 0, 0), "resume_7");
    add_idle(1, e(8'h00, 8'h00, 8'h06, 1, 0, 0, 0), "held_tick_to_6");
    add(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h06, 1, 0, 0, 0), "start_in_run");

    // Reset state.
    #1 rst = 1'b1;
    #2 check_now(e(8'h00, 8'h00, 8'h00, 0, 0, 0, 0), "reset_state");
    @(posedge clk_core);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].st, vecs[i].ps, vecs[i].mn, vecs[i].sc, vecs[i].ms,
           vecs[i].exp, vecs[i].name);
    end

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    // Auto-reload: done_pulse every 8 cycles, the count returns to 02 and
    // running stays high.
    step(1, 0, 0, 8'h00, 8'h00, 8'h02, e(8'h00, 8'h00, 8'h02, 0, 0, 0, 0), "ar_load_2");
    step(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h02, 1, 0, 0, 0), "ar_start");
    for (int i = 1; i <= 24; i++) begin
      idle(e(8'h00, 8'h00, ((i % 8) >= 4) ? 8'h01 : 8'h02, 1, 0, (i % 8) == 0, 0),
           "ar_cycle");
    end
`else
    // Expiry from RUN, then the timer stays in EXPIRED with no further pulses.
    step(1, 0, 0, 8'h00, 8'h00, 8'h01, e(8'h00, 8'h00, 8'h01, 0, 0, 0, 0), "load_1");
    step(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h01, 1, 0, 0, 0), "start_1");
    for (int i = 0; i < 3; i++) begin
      idle(e(8'h00, 8'h00, 8'h01, 1, 0, 0, 0), "run_last");
    end
    idle(e(8'h00, 8'h00, 8'h00, 0, 1, 1, 0), "expire_last");
    for (int i = 0; i < 10; i++) begin
      idle(e(8'h00, 8'h00, 8'h00, 0, 1, 0, 0), "stay_expired");
    end
`endif

    // Asynchronous reset between edges while in RUN.
    step(1, 0, 0, 8'h00, 8'h00, 8'h09, e(8'h00, 8'h00, 8'h09, 0, 0, 0, 0), "load_9");
    step(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h09, 1, 0, 0, 0), "start_9");
    idle(e(8'h00, 8'h00, 8'h09, 1, 0, 0, 0), "run_9");
    idle(e(8'h00, 8'h00, 8'h09, 1, 0, 0, 0), "run_9");
    #3 rst = 1'b1;
    #1 check_now(e(8'h00, 8'h00, 8'h00, 0, 0, 0, 0), "async_reset_immediate");
    @(posedge clk_core);
    #1 check_now(e(8'h00, 8'h00, 8'h00, 0, 0, 0, 0), "reset_held");
    rst = 1'b0;
    step(0, 1, 0, 8'h00, 8'h00, 8'h00, e(8'h00, 8'h00, 8'h00, 0, 0, 0, 0), "start_after_reset");
    idle(e(8'h00, 8'h00, 8'h00, 0, 0, 0, 0), "idle_after_reset2");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised countdown timer that stores the remaining time directly in BCD: minutes, seconds and 10 ms units.
- Decrements once per 10 ms tick, derived from clk_core by an internal prescaler.
- Adds load/start/pause control, preset validation and a one-cycle expiry pulse.
- Sits between the keypad/preset logic and the 7-segment display mux; its outputs drive the display directly.

Parameters:
CLK_DIV, 100000, clk_core cycles per 10 ms tick (legal range >=2)
MIN_DIGITS, 2, number of BCD minute digits (legal range 1..4); max minutes = 10^MIN_DIGITS-1

Ports:
clk_core  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
load  in  1  1-cycle pulse: capture preset from min_i/sec_i/ms_10_i
start  in  1  1-cycle pulse: begin or resume counting
pause  in  1  1-cycle pulse: freeze counting
min_i  in  4*MIN_DIGITS  preset minutes, BCD, digit 0 in the LSBs
sec_i  in  8  preset seconds, BCD 00..59
ms_10_i  in  8  preset 10 ms units, BCD 00..99
min_o  out  4*MIN_DIGITS  remaining minutes, BCD
sec_o  out  8  remaining seconds, BCD
ms_10_o  out  8  remaining 10 ms units, BCD
running  out  1  high while in state RUN
time_out  out  1  sticky expiry flag
done_pulse  out  1  one-cycle pulse on expiry
bad_preset  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; prescaler=0.
  - min_o/sec_o/ms_10_o=0; running=0; time_out=0; done_pulse=0; bad_preset=0.
- States: IDLE, ARMED, RUN, EXPIRED. All outputs are registered; no combinational paths from inputs to outputs.
- Control priority in one cycle: load > pause > start.
- Preset validation on load:
  - Preset is invalid if any digit >9 or the sec tens digit >5.
  - ms_10 tens may be 0..9.
- load with a valid preset (accepted in any state):
  - Count registers take the preset on the next edge; prescaler=0; time_out=0.
  - Next state is ARMED; if the preset is all-zero, next state is EXPIRED with time_out=1 and done_pulse=1.
- load with an invalid preset:
  - bad_preset=1 for one cycle.
  - Count, state and time_out are unchanged.
- start:
  - ARMED->RUN.
  - Ignored in IDLE, RUN and EXPIRED.
- pause:
  - RUN->ARMED; prescaler value is held, not cleared, so a resume continues the partial tick.
  - Ignored in all other states.
- Prescaler:
  - Counts only in RUN, from 0 to CLK_DIV-1, then wraps to 0.
  - The tick is the cycle where prescaler==CLK_DIV-1.
- On tick, the count decrements by one 10 ms unit with BCD borrow chain:
  - ms units 0->9 with borrow; ms tens 0->9 with borrow.
  - sec units 0->9 with borrow; sec tens 0->5 with borrow.
  - Each minute digit 0->9 with borrow.
  - Non-borrowing digits decrement by 1 at most once per tick.
- Expiry:
  - On the tick edge where the count goes from 0..0:00:01 to all-zero: state->EXPIRED, time_out=1, done_pulse=1 for exactly that one cycle, running=0 in the same cycle.
  - Count is never decremented below zero.
- Output timing:
  - Outputs update on the clock edge that samples the tick or the load (latency 1 cycle).
  - running follows state with the same 1-cycle latency.
- Simultaneous events:
  - load on a tick cycle: load wins and no decrement occurs.
  - pause on a tick cycle: pause wins and no decrement occurs.
- Mid-operation reset: rst asserted in any state clears everything immediately, with no done_pulse.

Optional Feature:
- Macro: BCD_COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - A shadow register keeps the last accepted non-zero preset.
  - On expiry from RUN, the count reloads from the shadow at the same edge and the state stays RUN.
  - done_pulse=1 for one cycle; time_out stays 0; prescaler restarts at 0.
  - An all-zero load still goes to EXPIRED with time_out=1.
- Not defined: behaviour as above (stop in EXPIRED); no shadow register is synthesised.

Test Plan:
- CLK_DIV=4, MIN_DIGITS=2: reset, load 00:00:03, start -> outputs 00:00:02, 00:00:01, 00:00:00 at edges 4, 8, 12 after start; done_pulse high exactly 1 cycle at the last edge; time_out stays 1; running 0.
- Borrow chain: load 01:00:00, start, 1 tick -> 00:59:99; load 10:00:00, 1 tick -> 09:59:99.
- Pause/resume: load 00:00:05, start, pause after 2 clk_core cycles, hold 20 cycles -> value unchanged; start -> next decrement 2 cycles later, to 00:00:04.
- Validation: load sec_i=8'h60 or ms_10_i=8'h1A -> bad_preset pulses 1 cycle; count and state unchanged; load all-zero -> EXPIRED, done_pulse 1 cycle, time_out=1.
- Priority/reset: load coinciding with a tick -> preset loaded, no decrement; rst asserted mid-RUN between clock edges -> outputs 0 immediately, state IDLE, no done_pulse.
- With BCD_COUNTDOWN_AUTO_RELOAD_EN, load 00:00:02, start -> done_pulse every 8 cycles, count reloads to 00:00:02, time_out stays 0, running stays 1.
